// File: rtl/al422_wr_pkg.sv
// rtl/al422_wr_pkg.sv - shared types and constants for the AL422B write front end
package al422_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RST   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int DEF_FRAME_BYTES = 192;  // 8 px x 8 rows x 3 bytes
  localparam int DEF_WRST_WCK    = 2;

  // Idle levels of the AL422B write pins
  localparam logic       RST_WCK    = 1'b0;
  localparam logic       RST_WE_N   = 1'b1;
  localparam logic       RST_WRST_N = 1'b1;
  localparam logic [7:0] RST_DATA   = 8'h00;

endpackage

// File: rtl/al422_wr_if.sv
// rtl/al422_wr_if.sv - framed byte stream from the host link
interface al422_wr_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_sof;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_sof, input s_ready);
  modport slave  (input s_data, input s_valid, input s_sof, output s_ready);

endinterface

// File: rtl/al422_wr_phase.sv
// rtl/al422_wr_phase.sv - divide-by-two WCK phase generator, shared with the read side
module al422_wr_phase
  import al422_wr_pkg::*;
(
  input  logic in_clk,
  input  logic in_nrst,
  output logic wck,
  output logic fall_cyc
);

  logic wck_q;

  // Toggle every cycle; the cycle with wck high precedes the falling edge
  always_ff @(posedge in_clk) begin
    if (!in_nrst) wck_q <= RST_WCK;
    else          wck_q <= ~wck_q;
  end

  assign wck      = wck_q;
  assign fall_cyc = wck_q;

endmodule

// File: rtl/al422b_writer.sv
// rtl/al422b_writer.sv - AL422B write-side framer; AL422_WR_SOF_RESYNC_EN enables restart on early sof
module al422b_writer
  import al422_wr_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int WRST_WCK    = DEF_WRST_WCK
) (
  input  logic        in_clk,
  input  logic        in_nrst,
  al422_wr_if.slave   s,
  output logic        al422_wck,
  output logic        al422_we_n,
  output logic        al422_wrst_n,
  output logic [7:0]  al422_data,
  output logic        frame_done,
  output logic        err_sync
);

  localparam int                CNT_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_BYTES - 1);
  localparam logic [3:0]        RST_LAST = 4'(WRST_WCK - 1);

  logic wck, fall_cyc, hs;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]        rst_cnt_q, rst_cnt_d;
  logic              we_n_q, we_n_d;
  logic              wrst_n_q, wrst_n_d;
  logic [7:0]        data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_sync_q, err_sync_d;

  al422_wr_phase u_phase (
    .in_clk   (in_clk),
    .in_nrst  (in_nrst),
    .wck      (wck),
    .fall_cyc (fall_cyc)
  );

  // Ready depends only on state, phase and sof so s_valid never loops back
  always_comb begin
    s.s_ready = 1'b0;
    case (state_q)
      ST_IDLE:  s.s_ready = wck & ~s.s_sof;
`ifdef AL422_WR_SOF_RESYNC_EN
      ST_WRITE: s.s_ready = wck & ~s.s_sof;
`else
      ST_WRITE: s.s_ready = wck;
`endif
      default:  s.s_ready = 1'b0;
    endcase
  end

  assign hs = s.s_valid & s.s_ready;

  // Next-state and pin values; everything but the pulses moves only on fall cycles
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    we_n_d       = we_n_q;
    wrst_n_d     = wrst_n_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    err_sync_d   = 1'b0;
    if (fall_cyc) begin
      case (state_q)
        ST_IDLE: begin
          we_n_d = 1'b1;
          if (hs) begin
            err_sync_d = 1'b1;
          end else if (s.s_valid && s.s_sof) begin
            state_d   = ST_RST;
            wrst_n_d  = 1'b0;
            rst_cnt_d = '0;
          end
        end
        ST_RST: begin
          we_n_d = 1'b1;
          if (rst_cnt_q == RST_LAST) begin
            state_d  = ST_WRITE;
            wrst_n_d = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q + 4'd1;
          end
        end
        ST_WRITE: begin
          if (hs) begin
            data_d = s.s_data;
            we_n_d = 1'b0;
            if (byte_cnt_q == LAST_IDX) begin
              frame_done_d = 1'b1;
              byte_cnt_d   = '0;
              state_d      = ST_IDLE;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            we_n_d = 1'b1;
`ifdef AL422_WR_SOF_RESYNC_EN
            if (s.s_valid && s.s_sof) begin
              err_sync_d = 1'b1;
              byte_cnt_d = '0;
              state_d    = ST_RST;
              wrst_n_d   = 1'b0;
              rst_cnt_d  = '0;
            end
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and pin registers with synchronous reset to the idle pin levels
  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      we_n_q       <= RST_WE_N;
      wrst_n_q     <= RST_WRST_N;
      data_q       <= RST_DATA;
      frame_done_q <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      we_n_q       <= we_n_d;
      wrst_n_q     <= wrst_n_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      err_sync_q   <= err_sync_d;
    end
  end

  assign al422_wck    = wck;
  assign al422_we_n   = we_n_q;
  assign al422_wrst_n = wrst_n_q;
  assign al422_data   = data_q;
  assign frame_done   = frame_done_q;
  assign err_sync     = err_sync_q;

endmodule

// File: tb/tb_al422b_writer.sv
// tb/tb_al422b_writer.sv - directed bench for al422b_writer with FRAME_BYTES=4, WRST_WCK=2
module tb_al422b_writer;

  logic       in_clk = 1'b0;
  logic       in_nrst;
  logic       al422_wck, al422_we_n, al422_wrst_n, frame_done, err_sync;
  logic [7:0] al422_data;

  al422_wr_if sif ();

  al422b_writer #(.FRAME_BYTES(4), .WRST_WCK(2)) dut (
    .in_clk       (in_clk),
    .in_nrst      (in_nrst),
    .s            (sif),
    .al422_wck    (al422_wck),
    .al422_we_n   (al422_we_n),
    .al422_wrst_n (al422_wrst_n),
    .al422_data   (al422_data),
    .frame_done   (frame_done),
    .err_sync     (err_sync)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad   = 0;

  // AL422-side observer: a byte is written when WCK is high with we_n low
  logic [7:0] wr_log [256];
  int wr_n = 0, wrst_low = 0, fd_n = 0, err_n = 0;

  always @(negedge in_clk) begin
    if (in_nrst === 1'b1) begin
      if (al422_wck === 1'b1 && al422_we_n === 1'b0 && wr_n < 256) begin
        wr_log[wr_n] <= al422_data;
        wr_n <= wr_n + 1;
      end
      if (al422_wrst_n === 1'b0) wrst_low <= wrst_low + 1;
      if (frame_done === 1'b1)   fd_n <= fd_n + 1;
      if (err_sync === 1'b1)     err_n <= err_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  // Present one byte, wait (bounded) for ready, then complete the handshake
  task automatic send_byte(input logic [7:0] d, input logic sof, input bit is_write, input logic fd);
    int n;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_sof   = sof;
    n = 0;
    while (sif.s_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) check("ready_timeout", 32'(n), 32'd0);
    step();
    sif.s_valid = 1'b0;
    sif.s_sof   = 1'b0;
    if (is_write) begin
      check("wr_data", al422_data, d);
      check("wr_we_n", al422_we_n, 1'b0);
      check("wr_fd", frame_done, fd);
    end else begin
      check("drop_err", err_sync, 1'b1);
      check("drop_we_n", al422_we_n, 1'b1);
    end
  endtask

  task automatic expect_entry(input string tag, input int idx, input logic [7:0] exp);
    check(tag, wr_log[idx], exp);
  endtask

  int ws, rl, fs, es, n;

  initial begin
    in_nrst     = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_sof   = 1'b0;
    sif.s_data  = 8'h00;

    // Reset values
    repeat (4) step();
    check("rst_wck", al422_wck, 1'b0);
    check("rst_we_n", al422_we_n, 1'b1);
    check("rst_wrst_n", al422_wrst_n, 1'b1);
    check("rst_data", al422_data, 8'h00);
    check("rst_ready", sif.s_ready, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_err", err_sync, 1'b0);
    in_nrst = 1'b1;
    step();
    check("wck_t1", al422_wck, 1'b1);
    step();
    check("wck_t2", al422_wck, 1'b0);

    // Nominal frame with sof latency measured from the fall cycle
    ws = wr_n; rl = wrst_low; fs = fd_n; es = err_n;
    sif.s_valid = 1'b1;
    sif.s_sof   = 1'b1;
    sif.s_data  = 8'h11;
    if (al422_wck !== 1'b1) step();
    n = 0;
    while (sif.s_ready !== 1'b1 && n < 40) begin
      step();
      n++;
      if (n == 1) check("nom_wrst_low", al422_wrst_n, 1'b0);
    end
    check("nom_sof_lat", 32'(n), 32'd6);
    step();
    sif.s_valid = 1'b0;
    sif.s_sof   = 1'b0;
    check("nom_d0", al422_data, 8'h11);
    check("nom_we0", al422_we_n, 1'b0);
    check("nom_wrst_rel", al422_wrst_n, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1, 1'b1);
    step();
    check("nom_fd_pulse", frame_done, 1'b0);
    check("nom_we_last", al422_we_n, 1'b0);
    repeat (3) step();
    check("nom_we_idle", al422_we_n, 1'b1);
    check("nom_ready_sof", sif.s_ready, 1'b0);
    check("nom_nwr", 32'(wr_n - ws), 32'd4);
    expect_entry("nom_w0", ws + 0, 8'h11);
    expect_entry("nom_w1", ws + 1, 8'h22);
    expect_entry("nom_w2", ws + 2, 8'h33);
    expect_entry("nom_w3", ws + 3, 8'h44);
    check("nom_wrst_cyc", 32'(wrst_low - rl), 32'd4);
    check("nom_fd_cnt", 32'(fd_n - fs), 32'd1);
    check("nom_err_cnt", 32'(err_n - es), 32'd0);

    // Backpressure gap mid-frame
    ws = wr_n; fs = fd_n;
    send_byte(8'h5a, 1'b1, 1'b1, 1'b0);
    send_byte(8'h6b, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    check("gap_we_n", al422_we_n, 1'b1);
    check("gap_data", al422_data, 8'h6b);
    send_byte(8'h7c, 1'b0, 1'b1, 1'b0);
    send_byte(8'h8d, 1'b0, 1'b1, 1'b1);
    repeat (4) step();
    check("gap_nwr", 32'(wr_n - ws), 32'd4);
    expect_entry("gap_w0", ws + 0, 8'h5a);
    expect_entry("gap_w1", ws + 1, 8'h6b);
    expect_entry("gap_w2", ws + 2, 8'h7c);
    expect_entry("gap_w3", ws + 3, 8'h8d);
    check("gap_fd_cnt", 32'(fd_n - fs), 32'd1);

    // Non-sof bytes in IDLE are dropped with an error each
    ws = wr_n; rl = wrst_low; es = err_n;
    send_byte(8'ha1, 1'b0, 1'b0, 1'b0);
    send_byte(8'ha2, 1'b0, 1'b0, 1'b0);
    send_byte(8'ha3, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    check("drop_err_cnt", 32'(err_n - es), 32'd3);
    check("drop_wrst_cnt", 32'(wrst_low - rl), 32'd0);
    check("drop_nwr", 32'(wr_n - ws), 32'd0);
    check("drop_wrst_n", al422_wrst_n, 1'b1);

    // Early sof after two bytes
    ws = wr_n; rl = wrst_low; fs = fd_n; es = err_n;
    send_byte(8'h11, 1'b1, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1, 1'b0);
`ifdef AL422_WR_SOF_RESYNC_EN
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b1, 1'b0);
    send_byte(8'h77, 1'b0, 1'b1, 1'b0);
    send_byte(8'h88, 1'b0, 1'b1, 1'b1);
    repeat (4) step();
    check("es_nwr", 32'(wr_n - ws), 32'd6);
    expect_entry("es_w2", ws + 2, 8'h55);
    expect_entry("es_w5", ws + 5, 8'h88);
    check("es_wrst_cyc", 32'(wrst_low - rl), 32'd8);
    check("es_err_cnt", 32'(err_n - es), 32'd1);
`else
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b1, 1'b1);
    send_byte(8'h77, 1'b0, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    check("es_nwr", 32'(wr_n - ws), 32'd4);
    expect_entry("es_w2", ws + 2, 8'h55);
    expect_entry("es_w3", ws + 3, 8'h66);
    check("es_wrst_cyc", 32'(wrst_low - rl), 32'd4);
    check("es_err_cnt", 32'(err_n - es), 32'd2);
`endif
    expect_entry("es_w0", ws + 0, 8'h11);
    expect_entry("es_w1", ws + 1, 8'h22);
    check("es_fd_cnt", 32'(fd_n - fs), 32'd1);

    // Reset while we_n is low, then a clean frame
    send_byte(8'h99, 1'b1, 1'b1, 1'b0);
    in_nrst = 1'b0;
    step();
    check("mr_we_n", al422_we_n, 1'b1);
    check("mr_wck", al422_wck, 1'b0);
    check("mr_wrst_n", al422_wrst_n, 1'b1);
    check("mr_data", al422_data, 8'h00);
    check("mr_ready", sif.s_ready, 1'b0);
    in_nrst = 1'b1;
    ws = wr_n; rl = wrst_low; fs = fd_n;
    send_byte(8'hc1, 1'b1, 1'b1, 1'b0);
    send_byte(8'hc2, 1'b0, 1'b1, 1'b0);
    send_byte(8'hc3, 1'b0, 1'b1, 1'b0);
    send_byte(8'hc4, 1'b0, 1'b1, 1'b1);
    repeat (4) step();
    check("mr_nwr", 32'(wr_n - ws), 32'd4);
    expect_entry("mr_w0", ws + 0, 8'hc1);
    expect_entry("mr_w3", ws + 3, 8'hc4);
    check("mr_wrst_cyc", 32'(wrst_low - rl), 32'd4);
    check("mr_fd_cnt", 32'(fd_n - fs), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
